// File: rtl/a2d_spi_pkg.sv
// Shared constants and types for the A2D SPI responder.
// Holds frame/data widths, the position of the channel field in a command
// word, and the responder FSM state type.
package a2d_spi_pkg;

  localparam int unsigned NUM_CH       = 8;
  localparam int unsigned DATA_W       = 12;
  localparam int unsigned FRAME_W      = 16;
  localparam int unsigned CH_FIELD_MSB = 13;
  localparam int unsigned CH_FIELD_LSB = 11;
  // Wide enough to hold the saturation value FRAME_W + 1.
  localparam int unsigned CNT_W        = 5;

  typedef enum logic {IDLE, SHIFT} spi_resp_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer plus a history flop for one asynchronous SPI pin.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   d_i       asynchronous pin input
//   level_o   synchronized level
//   rise_o    1-clk pulse on a synchronized 0->1 transition
//   fall_o    1-clk pulse on a synchronized 1->0 transition
module spi_edge_sync #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RstVal;
      sync2_q <= RstVal;
      hist_q  <= RstVal;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~hist_q;
  assign fall_o  = ~sync2_q & hist_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating an 8-channel, 12-bit A2D converter.
// Each 16-bit frame shifts in a command on MOSI and shifts out, on MISO, the
// conversion for the channel captured from the previous complete command.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   SS_n       slave select (active low, async)
//   SCLK       SPI clock (idles high, async)
//   MOSI       command bits, MSB first
//   MISO       response bits, MSB first; 1 while idle
//   chan_val   packed channel values, ch n at [n*12 +: 12]
//   last_chnl  channel field of the last complete command
//   cmd_data   last complete command word
//   cmd_vld    1-clk pulse when a complete frame closes
//   frame_err  1-clk pulse when a frame closes with the wrong bit count
module adc_spi_responder
  import a2d_spi_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SS_n,
  input  logic                     SCLK,
  input  logic                     MOSI,
  output logic                     MISO,
  input  logic [NUM_CH*DATA_W-1:0] chan_val,
  output logic [2:0]               last_chnl,
  output logic [FRAME_W-1:0]       cmd_data,
  output logic                     cmd_vld,
  output logic                     frame_err
);

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CntSat  = CNT_W'(FRAME_W + 1);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_edge_sync #(.RstVal(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SS_n),
    .level_o(ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_edge_sync #(.RstVal(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SCLK),
    .level_o(sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_edge_sync #(.RstVal(1'b0)) u_mosi_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (MOSI),
    .level_o(mosi_lvl),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall};

  spi_resp_state_t     state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [FRAME_W-1:0]  rx_q, rx_d;
  logic [2:0]          last_chnl_q, last_chnl_d;
  logic [FRAME_W-1:0]  cmd_data_q, cmd_data_d;
  logic                cmd_vld_q, cmd_vld_d;
  logic                frame_err_q, frame_err_d;
  logic                armed_q, armed_d;
  logic [1:0]          warm_q, warm_d;
  logic [DATA_W-1:0]   ch_sel;

  assign ch_sel = chan_val[last_chnl_q*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    last_chnl_d = last_chnl_q;
    cmd_data_d  = cmd_data_q;
    cmd_vld_d   = 1'b0;
    frame_err_d = 1'b0;

    // The sync flops come out of reset holding 1, so SS_n only counts as seen
    // high once the pipeline has been refilled from the pin.
    warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    armed_d = armed_q | ((warm_q == 2'd3) & ss_lvl);

    case (state_q)
      IDLE: begin
        if (ss_fall && armed_q) begin
          state_d   = SHIFT;
          tx_d      = {{(FRAME_W - DATA_W){1'b0}}, ch_sel};
          rx_d      = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_d = {rx_q[FRAME_W-2:0], mosi_lvl};
          if (bit_cnt_q != CntSat) bit_cnt_d = bit_cnt_q + 1'b1;
        end
        // The leading fall before the first rise must not consume the MSB.
        if (sclk_fall && (bit_cnt_q != '0)) tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        // Close on the post-rise values so a coincident last rise still counts.
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_d == CntFull) begin
            cmd_data_d  = rx_d;
            last_chnl_d = rx_d[CH_FIELD_MSB:CH_FIELD_LSB];
            cmd_vld_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      last_chnl_q <= '0;
      cmd_data_q  <= '0;
      cmd_vld_q   <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
      warm_q      <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      last_chnl_q <= last_chnl_d;
      cmd_data_q  <= cmd_data_d;
      cmd_vld_q   <= cmd_vld_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
      warm_q      <= warm_d;
    end
  end

  assign MISO      = (state_q == SHIFT) ? tx_q[FRAME_W-1] : 1'b1;
  assign last_chnl = last_chnl_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_vld   = cmd_vld_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder: the driver queues expected MISO words
// and frame-close events; independent monitors compare them as the DUT responds.
module tb_adc_spi_responder;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [95:0] chan_val;
  logic [2:0]  last_chnl;
  logic [15:0] cmd_data;
  logic        cmd_vld;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        chk;
    logic [15:0] word;
  } miso_exp_t;

  typedef struct packed {
    logic        is_err;
    logic [15:0] cmd;
    logic [2:0]  lc;
  } ev_exp_t;

  miso_exp_t miso_q[$];
  ev_exp_t   ev_q[$];
  logic [15:0] miso_acc = 16'h0;

  adc_spi_responder dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .chan_val (chan_val),
    .last_chnl(last_chnl),
    .cmd_data (cmd_data),
    .cmd_vld  (cmd_vld),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_miso(input logic c, input logic [15:0] w);
    miso_exp_t m;
    m.chk  = c;
    m.word = w;
    miso_q.push_back(m);
  endtask

  task automatic expect_ev(input logic is_err, input logic [15:0] cmd, input logic [2:0] lc);
    ev_exp_t e;
    e.is_err = is_err;
    e.cmd    = cmd;
    e.lc     = lc;
    ev_q.push_back(e);
  endtask

  // Drive one frame. MOSI changes on the SCLK fall; optional mid-frame
  // chan_val[ch2] change and reset pulse at a given bit index.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int rst_at,
                           input int chg_at, input logic [11:0] chg_val);
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      if (i == chg_at) chan_val[24 +: 12] = chg_val;
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(3);
        chk("miso_idle_after_rst", {31'h0, MISO}, 32'h1);
        chk("last_chnl_after_rst", {29'h0, last_chnl}, 32'h0);
      end
      wait_clk(HALF);
      SCLK = 1'b1;
      wait_clk(HALF);
    end
    SS_n = 1'b1;
    wait_clk(20);
  endtask

  // MISO monitor: collect bits at each SCLK rise, compare when the frame closes.
  initial begin
    forever begin
      @(posedge SCLK);
      if (SS_n == 1'b0) miso_acc = {miso_acc[14:0], MISO};
    end
  end

  initial begin
    miso_exp_t m;
    forever begin
      @(posedge SS_n);
      if (miso_q.size() > 0) begin
        m = miso_q.pop_front();
        if (m.chk) chk("miso_word", {16'h0, miso_acc}, {16'h0, m.word});
      end
      miso_acc = 16'h0;
    end
  end

  // Event monitor: every cmd_vld/frame_err cycle must match the next queued event.
  initial begin
    ev_exp_t e;
    forever begin
      @(negedge clk);
      if (cmd_vld || frame_err) begin
        chk("vld_err_exclusive", {31'h0, cmd_vld & frame_err}, 32'h0);
        if (ev_q.size() == 0) begin
          chk("unexpected_pulse", {30'h0, cmd_vld, frame_err}, 32'h0);
        end else begin
          e = ev_q.pop_front();
          chk("pulse_is_err", {31'h0, frame_err}, {31'h0, e.is_err});
          if (!e.is_err) begin
            chk("cmd_data", {16'h0, cmd_data}, {16'h0, e.cmd});
            chk("last_chnl", {29'h0, last_chnl}, {29'h0, e.lc});
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    chan_val = {12'h777, 12'h666, 12'h555, 12'hABC, 12'h333, 12'h123, 12'h111, 12'hC00};
    wait_clk(5);
    rst = 1'b0;
    wait_clk(1);
    chk("rst_miso", {31'h0, MISO}, 32'h1);
    chk("rst_last_chnl", {29'h0, last_chnl}, 32'h0);
    chk("rst_cmd_data", {16'h0, cmd_data}, 32'h0);
    chk("rst_cmd_vld", {31'h0, cmd_vld}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    wait_clk(10);

    // 1: two zero commands read ch0
    expect_miso(1'b1, 16'h0C00); expect_ev(1'b0, 16'h0000, 3'd0);
    spi_frame(16'h0000, 16, -1, -1, 12'h0);
    expect_miso(1'b1, 16'h0C00); expect_ev(1'b0, 16'h0000, 3'd0);
    spi_frame(16'h0000, 16, -1, -1, 12'h0);

    // 2: select ch4, then read it while selecting ch2
    expect_miso(1'b1, 16'h0C00); expect_ev(1'b0, 16'h2000, 3'd4);
    spi_frame(16'h2000, 16, -1, -1, 12'h0);
    expect_miso(1'b1, 16'h0ABC); expect_ev(1'b0, 16'h1000, 3'd2);
    spi_frame(16'h1000, 16, -1, -1, 12'h0);

    // 3: short frame
    expect_miso(1'b0, 16'h0); expect_ev(1'b1, 16'h0, 3'd0);
    spi_frame(16'hFFFF, 9, -1, -1, 12'h0);
    chk("short_hold_lc", {29'h0, last_chnl}, 32'd2);
    chk("short_hold_cmd", {16'h0, cmd_data}, 32'h1000);

    // 4: overrun frame
    expect_miso(1'b0, 16'h0); expect_ev(1'b1, 16'h0, 3'd0);
    spi_frame(16'h7800, 17, -1, -1, 12'h0);
    chk("overrun_hold_cmd", {16'h0, cmd_data}, 32'h1000);
    chk("overrun_hold_lc", {29'h0, last_chnl}, 32'd2);

    // 6: ch2 changes mid-frame; in-flight word keeps the snapshot
    expect_miso(1'b1, 16'h0123); expect_ev(1'b0, 16'h1000, 3'd2);
    spi_frame(16'h1000, 16, -1, 4, 12'h456);
    expect_miso(1'b1, 16'h0456); expect_ev(1'b0, 16'h0000, 3'd0);
    spi_frame(16'h0000, 16, -1, -1, 12'h0);

    // 5: reset mid-frame with SS_n held low; no events expected
    expect_miso(1'b0, 16'h0);
    spi_frame(16'h2000, 16, 7, -1, 12'h0);
    chk("post_rst_cmd_data", {16'h0, cmd_data}, 32'h0);
    expect_miso(1'b1, 16'h0C00); expect_ev(1'b0, 16'h2000, 3'd4);
    spi_frame(16'h2000, 16, -1, -1, 12'h0);
    expect_miso(1'b1, 16'h0ABC); expect_ev(1'b0, 16'h0000, 3'd0);
    spi_frame(16'h0000, 16, -1, -1, 12'h0);

    wait_clk(10);
    chk("ev_queue_drained", ev_q.size(), 32'h0);
    chk("miso_queue_drained", miso_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
